// File: rtl/cordic_cmd_sequencer.sv
// cordic_cmd_sequencer
// Queues CORDIC commands in a small FIFO and issues them one at a time to the
// calculator: one-cycle enable pulse, wait for a rising edge on done, then
// hand the result out on a valid/ready response port.
// Illegal op codes (10..15) are answered with an error response and never
// reach the calculator.
// Optional build macro: CORDIC_SEQ_TIMEOUT_EN adds a WAIT watchdog of
// TIMEOUT_CYCLES cycles that turns a missing done into an error response.
module cordic_cmd_sequencer #(
  parameter int WIDTH          = 32,
  parameter int DEPTH          = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [3:0]             cmd_op,
  input  logic [WIDTH-1:0]       cmd_x,
  input  logic [WIDTH-1:0]       cmd_y,
  input  logic [WIDTH-1:0]       cmd_z,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [WIDTH-1:0]       rsp_data,
  output logic [3:0]             rsp_op,
  output logic                   rsp_err,
  output logic                   cordic_enable,
  output logic [3:0]             cordic_operation,
  output logic [WIDTH-1:0]       cordic_x,
  output logic [WIDTH-1:0]       cordic_y,
  output logic [WIDTH-1:0]       cordic_z,
  input  logic [WIDTH-1:0]       cordic_result,
  input  logic                   cordic_done,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] fifo_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = 4 + 3 * WIDTH;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP
  } state_t;

  state_t           state_reg;
  logic [EW-1:0]    fifo_mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic             done_d_reg;
  logic             push;
  logic             pop;
  logic             done_edge;
  logic             timeout_hit;
  logic [3:0]       head_op;
  logic [WIDTH-1:0] head_x;
  logic [WIDTH-1:0] head_y;
  logic [WIDTH-1:0] head_z;

  // Readiness comes from the registered count only, so a full FIFO refuses a
  // push even in a cycle where the FSM pops.
  assign cmd_ready  = (count_reg < CW'(DEPTH));
  assign push       = cmd_valid & cmd_ready;
  assign pop        = (state_reg == ST_IDLE) && (count_reg != '0);
  assign {head_op, head_x, head_y, head_z} = fifo_mem[rd_ptr_reg];
  assign fifo_count = count_reg;
  assign busy       = (state_reg != ST_IDLE) || (count_reg != '0);
  // Only a fresh 0->1 transition counts, so a done left high by the previous
  // command cannot complete the current one.
  assign done_edge  = cordic_done & ~done_d_reg;

  // Command storage: plain array, no reset, so it maps onto RAM.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_reg] <= {cmd_op, cmd_x, cmd_y, cmd_z};
    end
  end

  // FIFO pointers (wrap naturally, DEPTH is a power of two) and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Registered copy of done for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_d_reg <= 1'b0;
    end else begin
      done_d_reg <= cordic_done;
    end
  end

`ifdef CORDIC_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] wait_cnt_reg;

  // The counter is 0 in the first WAIT cycle, so matching TIMEOUT_CYCLES-1
  // leaves WAIT after exactly TIMEOUT_CYCLES cycles without a done edge.
  assign timeout_hit = (state_reg == ST_WAIT) && !done_edge &&
                       (wait_cnt_reg == TW'(TIMEOUT_CYCLES - 1));

  // WAIT cycle counter: cleared while issuing, counts every WAIT cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt_reg <= '0;
    end else if (state_reg == ST_ISSUE) begin
      wait_cnt_reg <= '0;
    end else if (state_reg == ST_WAIT) begin
      wait_cnt_reg <= wait_cnt_reg + 1'b1;
    end
  end
`else
  // Without the watchdog WAIT is unbounded; TIMEOUT_CYCLES has no effect.
  assign timeout_hit = 1'b0;
  if (TIMEOUT_CYCLES < 1) begin : g_timeout_unused
  end
`endif

  // Main sequencer: pop, issue, wait for done edge, present response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg        <= ST_IDLE;
      cordic_enable    <= 1'b0;
      cordic_operation <= 4'hF;
      cordic_x         <= '0;
      cordic_y         <= '0;
      cordic_z         <= '0;
      rsp_valid        <= 1'b0;
      rsp_data         <= '0;
      rsp_op           <= '0;
      rsp_err          <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          cordic_enable <= 1'b0;
          if (pop) begin
            rsp_op <= head_op;
            if (head_op <= 4'd9) begin
              cordic_operation <= head_op;
              cordic_x         <= head_x;
              cordic_y         <= head_y;
              cordic_z         <= head_z;
              cordic_enable    <= 1'b1;
              state_reg        <= ST_ISSUE;
            end else begin
              rsp_data  <= '0;
              rsp_err   <= 1'b1;
              rsp_valid <= 1'b1;
              state_reg <= ST_RESP;
            end
          end
        end
        ST_ISSUE: begin
          cordic_enable <= 1'b0;
          state_reg     <= ST_WAIT;
        end
        ST_WAIT: begin
          if (done_edge || timeout_hit) begin
            rsp_data         <= done_edge ? cordic_result : '0;
            rsp_err          <= ~done_edge;
            rsp_valid        <= 1'b1;
            cordic_operation <= 4'hF;
            cordic_x         <= '0;
            cordic_y         <= '0;
            cordic_z         <= '0;
            state_reg        <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state_reg <= ST_IDLE;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_cmd_sequencer.sv
// Testbench for cordic_cmd_sequencer: stub calculator, random consumer,
// queue-based reference model of accepted commands and expected responses.
module tb_cordic_cmd_sequencer;

  localparam int W  = 32;
  localparam int D  = 4;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [3:0]    cmd_op;
  logic [W-1:0]  cmd_x, cmd_y, cmd_z;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [W-1:0]  rsp_data;
  logic [3:0]    rsp_op;
  logic          rsp_err;
  logic          cordic_enable;
  logic [3:0]    cordic_operation;
  logic [W-1:0]  cordic_x, cordic_y, cordic_z;
  logic [W-1:0]  cordic_result;
  logic          cordic_done;
  logic          busy;
  logic [CW-1:0] fifo_count;

  always #5 clk = ~clk;

  cordic_cmd_sequencer #(.WIDTH(W), .DEPTH(D), .TIMEOUT_CYCLES(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_z(cmd_z),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_op(rsp_op), .rsp_err(rsp_err),
    .cordic_enable(cordic_enable), .cordic_operation(cordic_operation),
    .cordic_x(cordic_x), .cordic_y(cordic_y), .cordic_z(cordic_z),
    .cordic_result(cordic_result), .cordic_done(cordic_done),
    .busy(busy), .fifo_count(fifo_count)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Stub calculator behaviour: multiply for op 4, arbitrary mix otherwise.
  function automatic logic [W-1:0] stub_f(input logic [3:0] op, input logic [W-1:0] x,
                                          input logic [W-1:0] y, input logic [W-1:0] z);
    logic signed [63:0] p;
    if (op == 4'd4) begin
      p = $signed(x) * $signed(z);
      return p[47:16];
    end
    return (x ^ {y[15:0], y[31:16]}) + z + {28'd0, op};
  endfunction

  // ---------------- stub calculator ----------------
  int           stub_lat   = 18;
  logic         stub_stall = 1'b0;
  logic         keep_done  = 1'b0;
  logic         man_done   = 1'b0;
  int           stub_cnt;
  logic         stub_done;
  logic [W-1:0] stub_res;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stub_cnt  <= 0;
      stub_done <= 1'b0;
      stub_res  <= '0;
    end else if (cordic_enable) begin
      stub_cnt  <= stub_lat;
      stub_done <= 1'b0;
      stub_res  <= stub_f(cordic_operation, cordic_x, cordic_y, cordic_z);
    end else if (stub_cnt != 0 && !stub_stall) begin
      if (stub_cnt == 1) stub_done <= 1'b1;
      stub_cnt <= stub_cnt - 1;
    end
  end

  assign cordic_done   = keep_done ? man_done : stub_done;
  assign cordic_result = stub_res;

  // ---------------- consumer ----------------
  logic rsp_hold = 1'b0;
  always @(posedge clk) begin
    #2;
    rsp_ready = rsp_hold ? 1'b0 : ($urandom_range(0, 3) != 0);
  end

  // ---------------- reference model ----------------
  typedef struct { logic [3:0] op; logic [W-1:0] x, y, z; } cmd_t;
  typedef struct { logic [W-1:0] data; logic [3:0] op; logic err; } rsp_t;
  cmd_t iss_q[$];
  rsp_t exp_q[$];
  logic exp_timeout = 1'b0;
  int   en_total = 0;
  int   en_run   = 0;
  int   n_rsp    = 0;
  logic prev_pending = 1'b0;
  logic [W+4:0] prev_rsp;

  // Accepted command -> expected response (and expected calculator issue).
  always @(negedge clk) begin
    if (rst_n && cmd_valid && cmd_ready) begin
      cmd_t c;
      rsp_t r;
      c.op = cmd_op; c.x = cmd_x; c.y = cmd_y; c.z = cmd_z;
      r.op = cmd_op;
      if (cmd_op <= 4'd9) begin
        iss_q.push_back(c);
        r.data = exp_timeout ? '0 : stub_f(cmd_op, cmd_x, cmd_y, cmd_z);
        r.err  = exp_timeout;
      end else begin
        r.data = '0;
        r.err  = 1'b1;
      end
      exp_q.push_back(r);
    end
  end

  // Calculator-side checks: operands at enable and one-cycle pulse width.
  always @(negedge clk) begin
    if (rst_n) begin
      if (cordic_enable) begin
        if (en_run == 0) begin
          en_total++;
          if (iss_q.size() == 0) check_eq("spurious_enable", 1, 0);
          else begin
            cmd_t c;
            c = iss_q.pop_front();
            check_eq("issue_op", cordic_operation, c.op);
            check_eq("issue_xyz", {cordic_x, cordic_y, cordic_z}, {c.x, c.y, c.z});
          end
        end
        en_run++;
      end else if (en_run != 0) begin
        check_eq("enable_width", en_run, 1);
        en_run = 0;
      end
    end
  end

  // Response-side checks: in-order contents and stability under backpressure.
  always @(negedge clk) begin
    if (rst_n) begin
      if (prev_pending)
        check_eq("rsp_stable", {rsp_valid, rsp_op, rsp_err, rsp_data}, {1'b1, prev_rsp});
      if (rsp_valid && rsp_ready) begin
        n_rsp++;
        if (exp_q.size() == 0) check_eq("spurious_rsp", 1, 0);
        else begin
          rsp_t r;
          r = exp_q.pop_front();
          check_eq("rsp_data", rsp_data, r.data);
          check_eq("rsp_op_err", {rsp_op, rsp_err}, {r.op, r.err});
        end
      end
      prev_pending = rsp_valid && !rsp_ready;
      prev_rsp     = {rsp_op, rsp_err, rsp_data};
    end else begin
      prev_pending = 1'b0;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_cmd(input logic [3:0] op, input logic [W-1:0] x,
                          input logic [W-1:0] y, input logic [W-1:0] z);
    int k;
    cmd_valid = 1'b1; cmd_op = op; cmd_x = x; cmd_y = y; cmd_z = z;
    k = 0;
    @(negedge clk);
    while (!cmd_ready && k < 500) begin
      @(negedge clk);
      k++;
    end
    if (cmd_ready) begin
      @(posedge clk);
      #1;
    end else begin
      check_eq("push_stuck", cmd_ready, 1);
    end
    cmd_valid = 1'b0;
  endtask

  task automatic wait_enable(input string tag);
    int k;
    k = 0;
    while (!cordic_enable && k < 50) begin tick(); k++; end
    if (!cordic_enable) check_eq(tag, cordic_enable, 1);
  endtask

  task automatic wait_rsp(input string tag, input int limit, output int k);
    k = 0;
    while (!rsp_valid && k < limit) begin tick(); k++; end
    if (!rsp_valid) check_eq(tag, rsp_valid, 1);
  endtask

  task automatic drain(input string tag);
    int k;
    k = 0;
    while ((exp_q.size() != 0 || busy) && k < 3000) begin tick(); k++; end
    check_eq(tag, {busy, 31'(exp_q.size())}, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- test sequence ----------------
  initial begin
    int k, en_before, rsp_before;
    logic seen;
    logic [W-1:0] snap;

    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_x = '0; cmd_y = '0; cmd_z = '0;
    rsp_ready = 1'b0;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_cordic", {cordic_enable, cordic_operation, cordic_x, cordic_y, cordic_z},
             {1'b0, 4'hF, 96'd0});
    check_eq("rst_rsp", {rsp_valid, rsp_data, rsp_op, rsp_err}, 0);
    check_eq("rst_fifo_busy", {fifo_count, busy}, 0);
    rst_n = 1'b1;
    tick();
    check_eq("ready_after_rst", cmd_ready, 1);

    // MULT: latency to enable, latency to response, result value.
    rsp_hold = 1'b1; stub_lat = 18; en_before = en_total;
    push_cmd(4'd4, 32'h0002_0000, 32'h0, 32'h0003_0000);
    k = 0;
    while (!cordic_enable && k < 20) begin tick(); k++; end
    check_eq("push_to_enable", k, 1);
    k = 0;
    while (!cordic_done && k < 60) begin tick(); k++; end
    wait_rsp("mult_no_rsp", 10, k);
    check_eq("done_to_rsp", k, 1);
    check_eq("mult_rsp", {rsp_data, rsp_op, rsp_err}, {32'h0006_0000, 4'd4, 1'b0});
    check_eq("mult_enables", en_total - en_before, 1);
    rsp_hold = 1'b0;
    drain("mult_drain");

    // Illegal op: error response, calculator untouched.
    rsp_hold = 1'b1; en_before = en_total;
    push_cmd(4'hF, $urandom, $urandom, $urandom);
    wait_rsp("illegal_no_rsp", 20, k);
    check_eq("illegal_rsp", {rsp_data, rsp_op, rsp_err}, {32'h0, 4'hF, 1'b1});
    check_eq("illegal_no_enable", en_total - en_before, 0);
    rsp_hold = 1'b0;
    drain("illegal_drain");

    // Random traffic with random latency, gaps and consumer stalls.
    for (int i = 0; i < 40; i++) begin
      logic [3:0] op;
      op = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
      stub_lat = $urandom_range(1, 20);
      push_cmd(op, $urandom, $urandom, $urandom);
      repeat ($urandom_range(0, 3)) tick();
    end
    drain("random_drain");

    // Backpressure/full: one command stalled in WAIT, four queued, fifth refused.
    stub_lat = 18; stub_stall = 1'b1; rsp_before = n_rsp;
    push_cmd(4'd0, 32'd100, 32'd0, 32'h0000_8000);
    wait_enable("full_first_enable");
    for (int i = 0; i < 4; i++) push_cmd(4'd0, 32'(i), 32'd0, 32'h0000_8000);
    cmd_valid = 1'b1; cmd_op = 4'd0; cmd_x = 32'd4; cmd_y = 32'd0; cmd_z = 32'h0000_8000;
    tick(); tick();
    check_eq("full_ready_count", {cmd_ready, fifo_count}, {1'b0, 3'd4});
    rsp_hold = 1'b1; stub_stall = 1'b0;
    wait_rsp("full_no_rsp", 100, k);
    snap = rsp_data;
    repeat (10) tick();
    check_eq("hold_stable", {rsp_valid, rsp_data}, {1'b1, snap});
    rsp_hold = 1'b0;
    push_cmd(4'd0, 32'd4, 32'd0, 32'h0000_8000);
    drain("full_drain");
    check_eq("full_rsp_count", n_rsp - rsp_before, 6);

    // Stale done: done already high before the command and held high.
    man_done = 1'b1; keep_done = 1'b1;
    push_cmd(4'd1, $urandom, $urandom, $urandom);
    seen = 1'b0;
    repeat (25) begin tick(); if (rsp_valid) seen = 1'b1; end
    check_eq("stale_no_capture", seen, 0);
    man_done = 1'b0;
    tick(); tick();
    man_done = 1'b1;
    wait_rsp("stale_no_rsp", 10, k);
    drain("stale_drain");
    keep_done = 1'b0; man_done = 1'b0;

    // Reset mid-WAIT with two commands still queued.
    for (int i = 0; i < 3; i++) push_cmd(4'd2, $urandom, $urandom, $urandom);
    wait_enable("rstw_enable");
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    check_eq("rstw_state", {fifo_count, busy, rsp_valid, cordic_enable, cordic_operation},
             {3'd0, 1'b0, 1'b0, 1'b0, 4'hF});
    iss_q.delete(); exp_q.delete(); en_run = 0;
    tick(); tick();
    rst_n = 1'b1;
    keep_done = 1'b1; man_done = 1'b1;
    tick(); tick();
    man_done = 1'b0;
    seen = 1'b0;
    repeat (20) begin tick(); if (rsp_valid || busy) seen = 1'b1; end
    check_eq("rstw_late_done", seen, 0);
    keep_done = 1'b0;

`ifdef CORDIC_SEQ_TIMEOUT_EN
    // Timeout: done never arrives.
    stub_stall = 1'b1; exp_timeout = 1'b1; rsp_hold = 1'b1;
    push_cmd(4'd2, $urandom, $urandom, $urandom);
    exp_timeout = 1'b0;
    wait_enable("tmo_enable");
    wait_rsp("tmo_no_rsp", 200, k);
    check_eq("tmo_latency", k, 65);
    check_eq("tmo_rsp", {rsp_data, rsp_err}, {32'h0, 1'b1});
    rsp_hold = 1'b0;
    drain("tmo_drain");
    stub_stall = 1'b0;
`endif

    check_eq("iss_q_left", iss_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
